posit_fixed_pipe: RTL and testbench

//  Parametrised, pipelined posit(N,ES)-to-signed-fixed-point converter for the posit ALU datapath.

---
 rtl/posit_fixed_pipe.sv | 175 +++++++++++++++++
 tb/tb_posit_fixed_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_fixed_pipe.sv
// Three-stage posit(N,ES) to signed Q(OUT_W-FRAC_W).FRAC_W fixed-point converter with saturation and NaR flag.
// Define POSIT_FIXED_ROUND_EN for round-to-nearest-even in S3; otherwise discarded bits are truncated.
module posit_fixed_pipe #(
    parameter int N      = 8,
    parameter int ES     = 1,
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_posit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_fx,
    output logic             out_ovf,
    output logic             out_nar
);

    localparam int MW = N + OUT_W;
    localparam int FB = N - 1;
    localparam logic [MW-1:0] MAX_MAG = {{(N+1){1'b0}}, {(OUT_W-1){1'b1}}};

    logic                    v1_d, v1_q, s1_d, s1_q, nar1_d, nar1_q, zero1_d, zero1_q;
    logic signed [7:0]       k1_d, k1_q;
    logic [N-2:0]            rem1_d, rem1_q;
    logic                    v2_d, v2_q, s2_d, s2_q, nar2_d, nar2_q, zero2_d, zero2_q;
    logic                    big2_d, big2_q;
    logic [MW-1:0]           mag2_d, mag2_q;
`ifdef POSIT_FIXED_ROUND_EN
    logic                    guard2_d, guard2_q, sticky2_d, sticky2_q;
`endif
    logic                    out_valid_d, out_valid_q, out_ovf_d, out_ovf_q, out_nar_d, out_nar_q;
    logic [OUT_W-1:0]        out_fx_d, out_fx_q;
    logic                    adv;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_fx    = out_fx_q;
    assign out_ovf   = out_ovf_q;
    assign out_nar   = out_nar_q;

    // S1: sign, absolute body, regime run-length; rem1 holds exponent+fraction left-aligned
    logic [N-2:0] body;
    logic         r0, run_done;
    int           run;
    always_comb begin
        v1_d     = in_valid;
        s1_d     = in_posit[N-1];
        nar1_d   = (in_posit == {1'b1, {(N-1){1'b0}}});
        zero1_d  = (in_posit == '0);
        body     = s1_d ? -in_posit[N-2:0] : in_posit[N-2:0];
        r0       = body[N-2];
        run      = 0;
        run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_done) begin
                if (body[i] == r0) run = run + 1;
                else               run_done = 1'b1;
            end
        end
        k1_d   = r0 ? 8'(run - 1) : 8'(-run);
        rem1_d = body << (run + 1);
    end

    // S2: scale = k*2^ES + e; shift the hidden-bit mantissa onto the FRAC_W grid
    int           e_val, sc, sh, rs;
    logic [N-2:0] frac;
    logic [N-1:0] mant;
    always_comb begin
        v2_d    = v1_q;
        s2_d    = s1_q;
        nar2_d  = nar1_q;
        zero2_d = zero1_q;
        e_val   = int'(rem1_q >> (FB - ES));
        frac    = rem1_q << ES;
        mant    = {1'b1, frac};
        sc      = int'(k1_q) * (2 ** ES) + e_val;
        sh      = sc + FRAC_W - FB;
        rs      = -sh;
        big2_d  = 1'b0;
        mag2_d  = '0;
`ifdef POSIT_FIXED_ROUND_EN
        guard2_d  = 1'b0;
        sticky2_d = 1'b0;
`endif
        if (sh >= OUT_W) begin
            big2_d = 1'b1;
        end else if (sh >= 0) begin
            mag2_d = MW'(mant) << sh;
        end else begin
            if (rs < N) mag2_d = MW'(mant >> rs);
`ifdef POSIT_FIXED_ROUND_EN
            for (int i = 0; i < N; i++) begin
                if (i == rs - 1) guard2_d  = guard2_d | mant[i];
                if (i < rs - 1)  sticky2_d = sticky2_d | mant[i];
            end
`endif
        end
    end

    // S3: optional rounding, saturate on the rounded magnitude, then apply sign
    logic [MW-1:0]    mag_r;
    logic             ovf;
    logic [OUT_W-1:0] fx_mag;
    always_comb begin
        out_valid_d = v2_q;
        mag_r       = mag2_q;
`ifdef POSIT_FIXED_ROUND_EN
        mag_r       = mag2_q + MW'(guard2_q & (sticky2_q | mag2_q[0]));
`endif
        ovf       = big2_q || (mag_r > MAX_MAG);
        fx_mag    = ovf ? MAX_MAG[OUT_W-1:0] : mag_r[OUT_W-1:0];
        out_fx_d  = s2_q ? -fx_mag : fx_mag;
        out_ovf_d = ovf;
        out_nar_d = 1'b0;
        if (nar2_q) begin
            out_fx_d  = {1'b1, {(OUT_W-1){1'b0}}};
            out_ovf_d = 1'b0;
            out_nar_d = 1'b1;
        end else if (zero2_q) begin
            out_fx_d  = '0;
            out_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            nar1_q      <= 1'b0;
            zero1_q     <= 1'b0;
            k1_q        <= '0;
            rem1_q      <= '0;
            v2_q        <= 1'b0;
            s2_q        <= 1'b0;
            nar2_q      <= 1'b0;
            zero2_q     <= 1'b0;
            big2_q      <= 1'b0;
            mag2_q      <= '0;
`ifdef POSIT_FIXED_ROUND_EN
            guard2_q    <= 1'b0;
            sticky2_q   <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            out_fx_q    <= '0;
            out_ovf_q   <= 1'b0;
            out_nar_q   <= 1'b0;
        end else if (adv) begin
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            nar1_q      <= nar1_d;
            zero1_q     <= zero1_d;
            k1_q        <= k1_d;
            rem1_q      <= rem1_d;
            v2_q        <= v2_d;
            s2_q        <= s2_d;
            nar2_q      <= nar2_d;
            zero2_q     <= zero2_d;
            big2_q      <= big2_d;
            mag2_q      <= mag2_d;
`ifdef POSIT_FIXED_ROUND_EN
            guard2_q    <= guard2_d;
            sticky2_q   <= sticky2_d;
`endif
            out_valid_q <= out_valid_d;
            out_fx_q    <= out_fx_d;
            out_ovf_q   <= out_ovf_d;
            out_nar_q   <= out_nar_d;
        end
    end

endmodule

// File: tb/tb_posit_fixed_pipe.sv
// Directed bench for posit_fixed_pipe: posit(8,1)->Q8.8 vector table, backpressure, mid-stream reset,
// and a posit(16,1)->Q12.4 instance for the rounding/truncation boundary.
`timescale 1ns/1ps
module tb_posit_fixed_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_nar;
    logic [7:0]  in_posit;
    logic [15:0] out_fx;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_out_nar;
    logic [15:0] b_in_posit, b_out_fx;

    always #5 clk = ~clk;

    posit_fixed_pipe #(.N(8), .ES(1), .OUT_W(16), .FRAC_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fx(out_fx), .out_ovf(out_ovf), .out_nar(out_nar)
    );

    posit_fixed_pipe #(.N(16), .ES(1), .OUT_W(16), .FRAC_W(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_posit(b_in_posit),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_fx(b_out_fx), .out_ovf(b_out_ovf), .out_nar(b_out_nar)
    );

    typedef struct packed {
        logic [7:0]  p;
        logic [15:0] fx;
        logic        ovf;
        logic        nar;
    } vec8_t;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] fx;
    } vec16_t;

    localparam int NV  = 19;
    localparam int NV16 = 6;
    vec8_t  vt[NV];
    vec16_t vb[NV16];
    int     bp_idx[6];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx_in, idx_out, first_cyc, extra, lat;
        logic stalled, seen;
        logic [15:0] prev_fx;
        logic prev_ovf, prev_nar;

        vt[0]  = '{8'h40, 16'h0100, 1'b0, 1'b0};
        vt[1]  = '{8'h50, 16'h0200, 1'b0, 1'b0};
        vt[2]  = '{8'h48, 16'h0180, 1'b0, 1'b0};
        vt[3]  = '{8'hC0, 16'hFF00, 1'b0, 1'b0};
        vt[4]  = '{8'h00, 16'h0000, 1'b0, 1'b0};
        vt[5]  = '{8'h80, 16'h8000, 1'b0, 1'b1};
        vt[6]  = '{8'h7F, 16'h7FFF, 1'b1, 1'b0};
        vt[7]  = '{8'h81, 16'h8001, 1'b1, 1'b0};
        vt[8]  = '{8'h01, 16'h0000, 1'b0, 1'b0};
        vt[9]  = '{8'h60, 16'h0400, 1'b0, 1'b0};
        vt[10] = '{8'h30, 16'h0080, 1'b0, 1'b0};
        vt[11] = '{8'hA0, 16'hFC00, 1'b0, 1'b0};
        vt[12] = '{8'h70, 16'h1000, 1'b0, 1'b0};
        vt[13] = '{8'h7A, 16'h7FFF, 1'b1, 1'b0};  // 32768 is one past the largest positive
        vt[14] = '{8'h79, 16'h6000, 1'b0, 1'b0};
        vt[15] = '{8'h02, 16'h0000, 1'b0, 1'b0};
        vt[16] = '{8'h20, 16'h0040, 1'b0, 1'b0};
        vt[17] = '{8'h86, 16'h8001, 1'b1, 1'b0};
        vt[18] = '{8'hB8, 16'hFE80, 1'b0, 1'b0};

        vb[0] = '{16'h4000, 16'h0010};
        vb[1] = '{16'h4060, 16'h0010};
`ifdef POSIT_FIXED_ROUND_EN
        vb[2] = '{16'h4080, 16'h0010};  // 16.5 ties to even
        vb[3] = '{16'h40C0, 16'h0011};
        vb[4] = '{16'hBF40, 16'hFFEF};
        vb[5] = '{16'h4180, 16'h0012};  // 17.5 ties to even
`else
        vb[2] = '{16'h4080, 16'h0010};
        vb[3] = '{16'h40C0, 16'h0010};
        vb[4] = '{16'hBF40, 16'hFFF0};
        vb[5] = '{16'h4180, 16'h0011};
`endif

        bp_idx[0] = 0; bp_idx[1] = 1; bp_idx[2] = 2;
        bp_idx[3] = 3; bp_idx[4] = 9; bp_idx[5] = 10;

        rst = 1'b1;
        in_valid = 1'b0; in_posit = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_posit = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_fx", out_fx, 0);
        check("reset out_ovf", out_ovf, 0);
        check("reset out_nar", out_nar, 0);
        check("reset in_ready", in_ready, 1);
        check("reset b_out_valid", b_out_valid, 0);
        rst = 1'b0;

        // vector table streamed back-to-back
        idx_in = 0; idx_out = 0; first_cyc = -1;
        for (int cyc = 0; cyc < NV + 12 && idx_out < NV; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                check($sformatf("vec%0d fx", idx_out), out_fx, vt[idx_out].fx);
                check($sformatf("vec%0d ovf", idx_out), out_ovf, vt[idx_out].ovf);
                check($sformatf("vec%0d nar", idx_out), out_nar, vt[idx_out].nar);
                idx_out++;
            end
            if (idx_in < NV) begin
                in_valid = 1'b1;
                in_posit = vt[idx_in].p;
                idx_in++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("table count", idx_out, NV);
        check("table first latency", first_cyc, 3);

        // backpressure: out_ready 1,0,0 repeating
        idx_in = 0; idx_out = 0; stalled = 1'b0;
        prev_fx = '0; prev_ovf = 1'b0; prev_nar = 1'b0;
        for (int cyc = 0; cyc < 60 && idx_out < 6; cyc++) begin
            @(posedge clk);
            #1;
            if (stalled) begin
                check("stall valid held", out_valid, 1);
                check("stall fx held", out_fx, prev_fx);
                check("stall flags held", {out_ovf, out_nar}, {prev_ovf, prev_nar});
            end
            out_ready = ((cyc % 3) == 0);
            if (idx_in < 6) begin
                in_valid = 1'b1;
                in_posit = vt[bp_idx[idx_in]].p;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("in_ready==adv", in_ready, (!out_valid || out_ready));
            if (out_valid && out_ready) begin
                check($sformatf("bp%0d fx", idx_out), out_fx, vt[bp_idx[idx_out]].fx);
                check($sformatf("bp%0d ovf", idx_out), out_ovf, vt[bp_idx[idx_out]].ovf);
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            stalled  = out_valid && !out_ready;
            prev_fx  = out_fx;
            prev_ovf = out_ovf;
            prev_nar = out_nar;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp count", idx_out, 6);
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        check("bp no duplicate", extra, 0);

        // reset with three words in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_posit = vt[i].p;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre-reset valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async reset drops valid", out_valid, 0);
        check("async reset clears fx", out_fx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        check("no stale after reset", extra, 0);
        in_valid = 1'b1;
        in_posit = 8'hC0;
        lat = -1; seen = 1'b0;
        for (int cyc = 1; cyc <= 10 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (out_valid) begin
                seen = 1'b1;
                lat = cyc;
                check("post-reset fx", out_fx, 16'hFF00);
            end
        end
        check("post-reset latency", lat, 3);

        // posit(16,1) -> Q12.4 rounding boundary
        idx_in = 0; idx_out = 0;
        for (int cyc = 0; cyc < NV16 + 12 && idx_out < NV16; cyc++) begin
            @(posedge clk);
            #1;
            if (b_out_valid) begin
                check($sformatf("p16 vec%0d fx", idx_out), b_out_fx, vb[idx_out].fx);
                check($sformatf("p16 vec%0d flags", idx_out), {b_out_ovf, b_out_nar}, 2'b00);
                idx_out++;
            end
            if (idx_in < NV16) begin
                b_in_valid = 1'b1;
                b_in_posit = vb[idx_in].p;
                idx_in++;
            end else begin
                b_in_valid = 1'b0;
            end
        end
        b_in_valid = 1'b0;
        check("p16 count", idx_out, NV16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
